// File: rtl/qdec_pkg.sv
// qdec_pkg: shared types, Gray-state constants and CW successor helper for the quadrature decoder
package qdec_pkg;

    typedef logic [1:0] ab_t;

    localparam ab_t AB_00 = 2'b00;
    localparam ab_t AB_10 = 2'b10;
    localparam ab_t AB_11 = 2'b11;
    localparam ab_t AB_01 = 2'b01;

    typedef enum logic [1:0] {NONE, CW, CCW, ILLEGAL} move_t;

    function automatic ab_t cw_next(input ab_t ab);
        return ab == AB_00 ? AB_10 : ab == AB_10 ? AB_11 : ab == AB_11 ? AB_01 : AB_00;
    endfunction

endpackage

// File: rtl/quad_step_fsm.sv
// quad_step_fsm: classifies a (prev_ab, cur_ab) pair into no move, CW, CCW or illegal jump
module quad_step_fsm
    import qdec_pkg::*;
(
    input  ab_t   prev_ab,
    input  ab_t   cur_ab,
    output move_t move
);

    // equal -> none, both bits flipped -> illegal, Gray successor -> CW, otherwise CCW
    always_comb begin
        move = cur_ab == prev_ab                 ? NONE    :
               (cur_ab ^ prev_ab) == 2'b11       ? ILLEGAL :
               cur_ab == cw_next(prev_ab)        ? CW      : CCW;
    end

endmodule

// File: rtl/quad_decoder.sv
// quad_decoder: quadrature A/B decoder with detent accumulator and signed position; QDEC_SAT_EN enables position clamping
module quad_decoder
    import qdec_pkg::*;
#(
    parameter int POS_W            = 16,
    parameter int STEPS_PER_DETENT = 4,
    parameter int POS_MIN          = -(2 ** (POS_W - 1)),
    parameter int POS_MAX          = 2 ** (POS_W - 1) - 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    a_in,
    input  logic                    b_in,
    input  logic                    clr,
    output logic                    step_cw,
    output logic                    step_ccw,
    output logic                    dir,
    output logic signed [POS_W-1:0] pos,
    output logic                    err
);

    if (POS_W < 4 || !(STEPS_PER_DETENT == 1 || STEPS_PER_DETENT == 2 || STEPS_PER_DETENT == 4)
        || POS_MIN > POS_MAX) begin : g_bad_params
        $error("quad_decoder: illegal parameter combination");
    end

    localparam logic signed [3:0]       SPD   = 4'(STEPS_PER_DETENT);
    localparam logic signed [POS_W-1:0] P_ONE = POS_W'(1);

    ab_t                    cur_ab;
    ab_t                    prev_ab;
    move_t                  move;
    logic                   primed;
    logic signed [2:0]      acc;
    logic signed [2:0]      acc_nxt;
    logic signed [3:0]      acc_inc;
    logic signed [3:0]      acc_dec;
    logic                   cw_hit;
    logic                   ccw_hit;
    logic                   err_nxt;
    logic signed [POS_W-1:0] pos_up;
    logic signed [POS_W-1:0] pos_dn;

    assign cur_ab = {a_in, b_in};

    quad_step_fsm u_step (
        .prev_ab (prev_ab),
        .cur_ab  (cur_ab),
        .move    (move)
    );

`ifdef QDEC_SAT_EN
    localparam logic signed [POS_W-1:0] P_MIN = POS_W'(POS_MIN);
    localparam logic signed [POS_W-1:0] P_MAX = POS_W'(POS_MAX);
    // a step at a limit still pulses but leaves pos at the clamp
    always_comb begin
        pos_up = pos >= P_MAX ? pos : pos + P_ONE;
        pos_dn = pos <= P_MIN ? pos : pos - P_ONE;
    end
`else
    // free-running position wraps modulo 2**POS_W
    always_comb begin
        pos_up = pos + P_ONE;
        pos_dn = pos - P_ONE;
    end
`endif

    // accumulate sub-detent transitions and flag detent completion or illegal jumps
    always_comb begin
        acc_inc = {acc[2], acc} + 4'sd1;
        acc_dec = {acc[2], acc} - 4'sd1;
        acc_nxt = acc;
        cw_hit  = 1'b0;
        ccw_hit = 1'b0;
        err_nxt = 1'b0;
        if (primed) begin
            if (move == ILLEGAL) begin
                err_nxt = 1'b1;
                acc_nxt = 3'sd0;
            end else if (move == CW) begin
                cw_hit  = acc_inc == SPD;
                acc_nxt = cw_hit ? 3'sd0 : acc_inc[2:0];
            end else if (move == CCW) begin
                ccw_hit = acc_dec == -SPD;
                acc_nxt = ccw_hit ? 3'sd0 : acc_dec[2:0];
            end
        end
    end

    // state and output registers; clr wins over a completing step but not over err
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_ab  <= AB_00;
            primed   <= 1'b0;
            acc      <= 3'sd0;
            pos      <= '0;
            dir      <= 1'b0;
            step_cw  <= 1'b0;
            step_ccw <= 1'b0;
            err      <= 1'b0;
        end else begin
            prev_ab  <= cur_ab;
            primed   <= 1'b1;
            err      <= err_nxt;
            step_cw  <= cw_hit && !clr;
            step_ccw <= ccw_hit && !clr;
            acc      <= clr ? 3'sd0 : acc_nxt;
            pos      <= clr ? '0 : cw_hit ? pos_up : ccw_hit ? pos_dn : pos;
            if (!clr && (cw_hit || ccw_hit))
                dir <= cw_hit;
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: scoreboard bench for quad_decoder (16-bit default and 4-bit/POS_MAX=5 instances)
module tb_quad_decoder;

`ifdef QDEC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int SPD = 4;

    typedef struct {
        int cw;
        int ccw;
        int dir;
        int pos;
        int err;
        int pos4;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic a_in = 1'b1;
    logic b_in = 1'b1;
    logic clr = 1'b0;
    logic step_cw, step_ccw, dir, err;
    logic signed [15:0] pos;
    logic step_cw4, step_ccw4, dir4, err4;
    logic signed [3:0] pos4;

    exp_t sb[$];
    int n_chk = 0;
    int n_fail = 0;
    int cnt_cw = 0;
    int cnt_ccw = 0;
    int cnt_cw4 = 0;

    int m_primed, m_acc, m_pos, m_pos4, m_dir;
    logic [1:0] m_prev;

    always #5 clk = ~clk;

    quad_decoder dut (
        .clk(clk), .rstn(rstn), .a_in(a_in), .b_in(b_in), .clr(clr),
        .step_cw(step_cw), .step_ccw(step_ccw), .dir(dir), .pos(pos), .err(err)
    );

    quad_decoder #(.POS_W(4), .POS_MAX(5)) dut4 (
        .clk(clk), .rstn(rstn), .a_in(a_in), .b_in(b_in), .clr(clr),
        .step_cw(step_cw4), .step_ccw(step_ccw4), .dir(dir4), .pos(pos4), .err(err4)
    );

    task automatic chk(input string tag, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
        end
    endtask

    function automatic int gidx(input logic [1:0] ab);
        return ab == 2'b00 ? 0 : ab == 2'b10 ? 1 : ab == 2'b11 ? 2 : 3;
    endfunction

    function automatic int wrap(input int v, input int w);
        int m = 1 << w;
        int h = 1 << (w - 1);
        return (((v + h) % m) + m) % m - h;
    endfunction

    // drive one cycle, push the model's expectation, compare after the edge
    task automatic tick(input logic a, input logic b, input logic c);
        exp_t e;
        exp_t g;
        logic [1:0] cur;
        int d;
        int hcw, hccw;
        cur = {a, b};
        a_in = a; b_in = b; clr = c;
        hcw = 0; hccw = 0; e.err = 0;
        if (m_primed != 0) begin
            d = (gidx(cur) - gidx(m_prev)) & 3;
            if (d == 2) begin e.err = 1; m_acc = 0; end
            else if (d == 1) m_acc++;
            else if (d == 3) m_acc--;
            if (m_acc == SPD) begin hcw = 1; m_acc = 0; end
            if (m_acc == -SPD) begin hccw = 1; m_acc = 0; end
        end
        m_prev = cur;
        m_primed = 1;
        if (c) begin
            m_acc = 0; m_pos = 0; m_pos4 = 0; hcw = 0; hccw = 0;
        end
        if (hcw != 0) begin
            m_dir = 1;
            m_pos = wrap(m_pos + 1, 16);
            m_pos4 = SAT ? (m_pos4 < 5 ? m_pos4 + 1 : m_pos4) : wrap(m_pos4 + 1, 4);
        end
        if (hccw != 0) begin
            m_dir = 0;
            m_pos = wrap(m_pos - 1, 16);
            m_pos4 = SAT ? (m_pos4 > -8 ? m_pos4 - 1 : m_pos4) : wrap(m_pos4 - 1, 4);
        end
        e.cw = hcw; e.ccw = hccw; e.dir = m_dir; e.pos = m_pos; e.pos4 = m_pos4;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk("step_cw", int'(step_cw), g.cw);
        chk("step_ccw", int'(step_ccw), g.ccw);
        chk("dir", int'(dir), g.dir);
        chk("pos", int'(pos), g.pos);
        chk("err", int'(err), g.err);
        chk("pos4", int'(pos4), g.pos4);
        chk("step_cw4", int'(step_cw4), g.cw);
        cnt_cw += int'(step_cw);
        cnt_ccw += int'(step_ccw);
        cnt_cw4 += int'(step_cw4);
        @(negedge clk);
    endtask

    task automatic go(input logic [1:0] ab, input int hold);
        repeat (hold) tick(ab[1], ab[0], 1'b0);
    endtask

    task automatic cw_detents(input int n, input int hold);
        repeat (n) begin
            go(2'b10, hold); go(2'b11, hold); go(2'b01, hold); go(2'b00, hold);
        end
    endtask

    // async reset with given input levels; reset values are constants
    task automatic do_reset(input logic a, input logic b);
        rstn = 1'b0; a_in = a; b_in = b; clr = 1'b0;
        m_primed = 0; m_acc = 0; m_pos = 0; m_pos4 = 0; m_dir = 0; m_prev = 2'b00;
        sb.delete();
        #2;
        chk("rst_async_pos", int'(pos), 0);
        repeat (2) @(negedge clk);
        chk("rst_step_cw", int'(step_cw), 0);
        chk("rst_step_ccw", int'(step_ccw), 0);
        chk("rst_dir", int'(dir), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_pos4", int'(pos4), 0);
        rstn = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        do_reset(1'b1, 1'b1);
        go(2'b11, 3);

        do_reset(1'b0, 1'b0);
        go(2'b00, 2);
        cw_detents(3, 5);
        chk("cw3_count", cnt_cw, 3);
        chk("cw3_pos", int'(pos), 3);
        chk("cw3_dir", int'(dir), 1);

        tick(1'b0, 1'b0, 1'b1);
        chk("clr_pos", int'(pos), 0);
        go(2'b10, 2); go(2'b11, 2); go(2'b10, 2); go(2'b00, 2);
        chk("half_cw", cnt_cw, 3);
        chk("half_ccw", cnt_ccw, 0);
        go(2'b01, 3); go(2'b11, 3); go(2'b10, 3); go(2'b00, 3);
        chk("ccw_count", cnt_ccw, 1);
        chk("ccw_pos", int'(pos), -1);
        chk("ccw_dir", int'(dir), 0);

        tick(1'b1, 1'b1, 1'b0);
        chk("jump_err", int'(err), 1);
        go(2'b11, 2);
        go(2'b01, 2); go(2'b00, 2); go(2'b10, 2); go(2'b11, 2);
        chk("post_err_pos", int'(pos), 0);
        chk("post_err_cw", cnt_cw, 4);

        go(2'b01, 2); go(2'b00, 2); go(2'b10, 2);
        tick(1'b1, 1'b1, 1'b1);
        chk("clr_step_cw", int'(step_cw), 0);
        go(2'b11, 2);
        chk("clr_hit_pos", int'(pos), 0);
        chk("clr_hit_cw", cnt_cw, 4);

        go(2'b01, 2); go(2'b00, 2);
        do_reset(1'b0, 1'b0);
        go(2'b00, 2);
        go(2'b10, 2); go(2'b11, 2); go(2'b01, 2);
        chk("mid_rst_nostep", cnt_cw, 4);
        go(2'b00, 2);
        chk("mid_rst_pos", int'(pos), 1);
        chk("mid_rst_cw", cnt_cw, 5);

        do_reset(1'b0, 1'b0);
        cnt_cw = 0; cnt_cw4 = 0;
        go(2'b00, 2);
        cw_detents(8, 2);
        chk("wrap_cw", cnt_cw, 8);
        chk("wrap_cw4", cnt_cw4, 8);
        chk("wrap_pos", int'(pos), 8);
        chk("wrap_pos4", int'(pos4), SAT ? 5 : -8);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
